// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding SRAM request, a one-entry instruction
// buffer and branch redirection. Define FS_PERF_CNT_EN to add the fs_perf_cnt counters.
module if_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
`ifdef FS_PERF_CNT_EN
  ,
  output logic [63:0] fs_perf_cnt
`endif
);

  localparam logic [31:0] RESET_PC = 32'h1BFF_FFFC;

  logic        fs_valid_q,       fs_valid_d;
  logic [31:0] fs_pc_q,          fs_pc_d;
  logic        outstanding_q,    outstanding_d;
  logic        cancel_q,         cancel_d;
  logic        br_buf_valid_q,   br_buf_valid_d;
  logic [31:0] br_buf_target_q,  br_buf_target_d;
  logic        ibuf_valid_q,     ibuf_valid_d;
  logic [31:0] ibuf_data_q,      ibuf_data_d;

  logic        br_taken_s;
  logic [31:0] br_target_s;
  logic        br_event_s;
  logic        data_ok_s;
  logic        good_data_s;
  logic        fs_ready_go_s;
  logic        fs_allowin_s;
  logic        accept_s;
  logic        deliver_s;
  logic [31:0] nextpc_s;
  logic [31:0] fs_inst_s;

  assign br_taken_s  = br_bus[32];
  assign br_target_s = br_bus[31:0];
  assign br_event_s  = br_taken_s && ds_allowin;

  // A data_ok only counts while our own request is in flight; this drops stale beats after reset.
  assign data_ok_s     = inst_sram_data_ok && outstanding_q;
  assign good_data_s   = data_ok_s && !cancel_q;
  assign fs_ready_go_s = (data_ok_s || ibuf_valid_q) && !cancel_q;
  assign fs_allowin_s  = !fs_valid_q || (fs_ready_go_s && ds_allowin);

  assign fs_to_ds_valid = fs_valid_q && fs_ready_go_s && !br_event_s;
  assign deliver_s      = fs_to_ds_valid && ds_allowin;

  assign inst_sram_req  = resetn && (!outstanding_q || data_ok_s) && fs_allowin_s;
  assign inst_sram_addr = nextpc_s;
  assign accept_s       = inst_sram_req && inst_sram_addr_ok;

  assign fs_to_ds_bus = {fs_inst_s, fs_pc_q};

  // Next fetch address and the instruction word presented to decode.
  always_comb begin
    nextpc_s  = fs_pc_q + 32'd4;
    fs_inst_s = 32'h0;
    if (br_event_s) begin
      nextpc_s = br_target_s;
    end else if (br_buf_valid_q) begin
      nextpc_s = br_buf_target_q;
    end else begin
      nextpc_s = fs_pc_q + 32'd4;
    end
    if (ibuf_valid_q) begin
      fs_inst_s = ibuf_data_q;
    end else if (data_ok_s) begin
      fs_inst_s = inst_sram_rdata;
    end else begin
      fs_inst_s = 32'h0;
    end
  end

  // Next-state logic for the fetch state, the cancel flag and both buffers.
  always_comb begin
    fs_valid_d      = fs_valid_q;
    fs_pc_d         = fs_pc_q;
    outstanding_d   = outstanding_q;
    cancel_d        = cancel_q;
    br_buf_valid_d  = br_buf_valid_q;
    br_buf_target_d = br_buf_target_q;
    ibuf_valid_d    = ibuf_valid_q;
    ibuf_data_d     = ibuf_data_q;

    // A newly accepted request owns the stage, even when it carries the branch target.
    if (accept_s) begin
      fs_valid_d = 1'b1;
      fs_pc_d    = nextpc_s;
    end else if (br_event_s || deliver_s) begin
      fs_valid_d = 1'b0;
    end else begin
      fs_valid_d = fs_valid_q;
    end

    if (accept_s) begin
      outstanding_d = 1'b1;
    end else if (data_ok_s) begin
      outstanding_d = 1'b0;
    end else begin
      outstanding_d = outstanding_q;
    end

    if (data_ok_s) begin
      cancel_d = 1'b0;
    end else if (br_event_s && outstanding_q) begin
      cancel_d = 1'b1;
    end else begin
      cancel_d = cancel_q;
    end

    if (br_event_s) begin
      ibuf_valid_d = 1'b0;
    end else if (good_data_s && !ds_allowin) begin
      ibuf_valid_d = 1'b1;
      ibuf_data_d  = inst_sram_rdata;
    end else if (deliver_s) begin
      ibuf_valid_d = 1'b0;
    end else begin
      ibuf_valid_d = ibuf_valid_q;
    end

    if (accept_s) begin
      br_buf_valid_d = 1'b0;
    end else if (br_event_s) begin
      br_buf_valid_d  = 1'b1;
      br_buf_target_d = br_target_s;
    end else begin
      br_buf_valid_d = br_buf_valid_q;
    end
  end

  // Fetch stage state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fs_valid_q      <= 1'b0;
      fs_pc_q         <= RESET_PC;
      outstanding_q   <= 1'b0;
      cancel_q        <= 1'b0;
      br_buf_valid_q  <= 1'b0;
      br_buf_target_q <= 32'h0;
      ibuf_valid_q    <= 1'b0;
      ibuf_data_q     <= 32'h0;
    end else begin
      fs_valid_q      <= fs_valid_d;
      fs_pc_q         <= fs_pc_d;
      outstanding_q   <= outstanding_d;
      cancel_q        <= cancel_d;
      br_buf_valid_q  <= br_buf_valid_d;
      br_buf_target_q <= br_buf_target_d;
      ibuf_valid_q    <= ibuf_valid_d;
      ibuf_data_q     <= ibuf_data_d;
    end
  end

`ifdef FS_PERF_CNT_EN
  logic [31:0] fetched_q,   fetched_d;
  logic [31:0] cancelled_q, cancelled_d;

  // A branch event with a live instruction (received or still in flight) discards it.
  always_comb begin
    fetched_d   = fetched_q;
    cancelled_d = cancelled_q;
    if (deliver_s) begin
      fetched_d = fetched_q + 32'd1;
    end else begin
      fetched_d = fetched_q;
    end
    if (br_event_s && fs_valid_q) begin
      cancelled_d = cancelled_q + 32'd1;
    end else begin
      cancelled_d = cancelled_q;
    end
  end

  // Performance counter registers, wrapping at 2^32.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetched_q   <= 32'h0;
      cancelled_q <= 32'h0;
    end else begin
      fetched_q   <= fetched_d;
      cancelled_q <= cancelled_d;
    end
  end

  assign fs_perf_cnt = {fetched_q, cancelled_q};
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage: one table row per clock cycle,
// followed by a hand-written back-to-back streaming sequence.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
`ifdef FS_PERF_CNT_EN
  logic [63:0] fs_perf_cnt;
`endif

  always #5 clk = ~clk;

  if_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ds_allowin        (ds_allowin),
    .br_bus            (br_bus),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
`ifdef FS_PERF_CNT_EN
    ,
    .fs_perf_cnt       (fs_perf_cnt)
`endif
  );

  typedef struct packed {
    logic        rst;
    logic        ds;
    logic        bt;
    logic [31:0] bta;
    logic        aok;
    logic        dok;
    logic [31:0] rd;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evld;
    logic [63:0] ebus;
  } vec_t;

  localparam int NV = 33;
  localparam logic [31:0] I0 = 32'hA000_0001, I1 = 32'hA111_1112, I3 = 32'hA333_3334;
  localparam logic [31:0] I4 = 32'hA444_4445, I5 = 32'hA555_5556, I6 = 32'hA666_6667;
  localparam logic [31:0] I7 = 32'hA777_7778, I8 = 32'hA888_8889, I9 = 32'hA999_9990;
  localparam logic [31:0] IA = 32'hAAAA_AAA1, IB = 32'hABBB_BBB2;
  localparam logic [63:0] RST_BUS = {32'h0, 32'h1BFF_FFFC};

  vec_t tbl [NV];
  int n_cmp = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic rst, input logic ds, input logic bt, input logic [31:0] bta,
                              input logic aok, input logic dok, input logic [31:0] rd,
                              input logic ereq, input logic [31:0] eaddr, input logic evld,
                              input logic [63:0] ebus);
    vec_t v;
    v.rst = rst; v.ds = ds; v.bt = bt; v.bta = bta; v.aok = aok; v.dok = dok; v.rd = rd;
    v.ereq = ereq; v.eaddr = eaddr; v.evld = evld; v.ebus = ebus;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %h, expected %h", nm, row, act, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; ds_allowin = 1'b1; br_bus = 33'h0;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;

    //          rst   ds    bt    bta            aok   dok   rdata          ereq  eaddr          evld  ebus
    tbl[0]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, RST_BUS);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, RST_BUS);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'hBAD0_0000, 1'b1, 32'h1C00_0000, 1'b0, 64'h0);
    tbl[3]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, I0,            1'b1, 32'h1C00_0004, 1'b1, {I0, 32'h1C00_0000});
    // decode stalls for three cycles starting with the data_ok of 0x1C000004
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, I1,            1'b0, 32'h0,         1'b1, {I1, 32'h1C00_0004});
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, {I1, 32'h1C00_0004});
    tbl[6]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, {I1, 32'h1C00_0004});
    tbl[7]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h1C00_0008, 1'b1, {I1, 32'h1C00_0004});
    // branch while 0x1C000008 is outstanding, its data_ok two cycles later is dropped
    tbl[8]  = mk(1'b1, 1'b1, 1'b1, 32'h1C00_0100, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 64'h0);
    tbl[9]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 64'h0);
    tbl[10] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'hBAD0_BAD0, 1'b1, 32'h1C00_0100, 1'b0, 64'h0);
    tbl[11] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, I3,            1'b1, 32'h1C00_0104, 1'b1, {I3, 32'h1C00_0100});
    // branch with addr_ok low for five cycles: request must hold 0x1C000100
    tbl[12] = mk(1'b1, 1'b1, 1'b1, 32'h1C00_0100, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1C00_0100, 1'b0, 64'h0);
    for (int k = 13; k <= 16; k++)
      tbl[k] = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,         1'b1, 32'h1C00_0100, 1'b0, 64'h0);
    tbl[17] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h1C00_0100, 1'b0, 64'h0);
    tbl[18] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, I4,            1'b1, 32'h1C00_0104, 1'b1, {I4, 32'h1C00_0100});
    // br_taken held four cycles under a decode stall, then one redirect
    tbl[19] = mk(1'b1, 1'b0, 1'b1, 32'h1C00_0200, 1'b1, 1'b1, I5,            1'b0, 32'h0,         1'b1, {I5, 32'h1C00_0104});
    for (int k = 20; k <= 22; k++)
      tbl[k] = mk(1'b1, 1'b0, 1'b1, 32'h1C00_0200, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,         1'b1, {I5, 32'h1C00_0104});
    tbl[23] = mk(1'b1, 1'b1, 1'b1, 32'h1C00_0200, 1'b1, 1'b0, 32'h0,         1'b1, 32'h1C00_0200, 1'b0, 64'h0);
    tbl[24] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, I6,            1'b1, 32'h1C00_0204, 1'b1, {I6, 32'h1C00_0200});
    tbl[25] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, I7,            1'b1, 32'h1C00_0208, 1'b1, {I7, 32'h1C00_0204});
    // reset mid-transaction, then a stray data_ok after release
    tbl[26] = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, RST_BUS);
    tbl[27] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'hBAD1_BAD1, 1'b1, 32'h1C00_0000, 1'b0, 64'h0);
    tbl[28] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h1C00_0000, 1'b0, 64'h0);
    tbl[29] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, I8,            1'b1, 32'h1C00_0004, 1'b1, {I8, 32'h1C00_0000});
    // branch coincident with data_ok, target chosen to exercise the 32-bit wrap
    tbl[30] = mk(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, I9,            1'b1, 32'hFFFF_FFFC, 1'b0, 64'h0);
    tbl[31] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, IA,            1'b1, 32'h0000_0000, 1'b1, {IA, 32'hFFFF_FFFC});
    tbl[32] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, IB,            1'b1, 32'h0000_0004, 1'b1, {IB, 32'h0000_0000});

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      resetn            = tbl[i].rst;
      ds_allowin        = tbl[i].ds;
      br_bus            = {tbl[i].bt, tbl[i].bta};
      inst_sram_addr_ok = tbl[i].aok;
      inst_sram_data_ok = tbl[i].dok;
      inst_sram_rdata   = tbl[i].rd;
      #2;
      chk("req", i, {63'h0, inst_sram_req}, {63'h0, tbl[i].ereq});
      chk("to_ds_valid", i, {63'h0, fs_to_ds_valid}, {63'h0, tbl[i].evld});
      if (tbl[i].ereq) chk("addr", i, {32'h0, inst_sram_addr}, {32'h0, tbl[i].eaddr});
      if (tbl[i].evld || !tbl[i].rst) chk("to_ds_bus", i, fs_to_ds_bus, tbl[i].ebus);
`ifdef FS_PERF_CNT_EN
      case (i)
        23: begin
          chk("perf_fetched", i, {32'h0, fs_perf_cnt[63:32]}, 64'd4);
          chk("perf_cancelled", i, {32'h0, fs_perf_cnt[31:0]}, 64'd1);
        end
        24: begin
          chk("perf_fetched", i, {32'h0, fs_perf_cnt[63:32]}, 64'd4);
          chk("perf_cancelled", i, {32'h0, fs_perf_cnt[31:0]}, 64'd2);
        end
        26: chk("perf_reset", i, fs_perf_cnt, 64'd0);
        32: begin
          chk("perf_fetched", i, {32'h0, fs_perf_cnt[63:32]}, 64'd2);
          chk("perf_cancelled", i, {32'h0, fs_perf_cnt[31:0]}, 64'd1);
        end
        default: ;
      endcase
`endif
    end

    // Back-to-back streaming with addr_ok/data_ok tied high after a fresh reset.
    @(negedge clk);
    resetn = 1'b0; br_bus = 33'h0; ds_allowin = 1'b1;
    inst_sram_addr_ok = 1'b1; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h0;
    #2;
    chk("stream_rst_req", 100, {63'h0, inst_sram_req}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      inst_sram_rdata = 32'hC000_0000 + 32'(k);
      #2;
      chk("stream_req", 101 + k, {63'h0, inst_sram_req}, 64'd1);
      chk("stream_addr", 101 + k, {32'h0, inst_sram_addr}, {32'h0, 32'h1C00_0000 + 32'(4 * k)});
      chk("stream_valid", 101 + k, {63'h0, fs_to_ds_valid}, {63'h0, (k > 0)});
      if (k > 0)
        chk("stream_bus", 101 + k, fs_to_ds_bus,
            {32'hC000_0000 + 32'(k), 32'h1C00_0000 + 32'(4 * (k - 1))});
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
